// File: rtl/spmv_csr_accum.sv
// Sparse matrix-vector accumulator for matrices in CSR form.
// Each nonzero/vector pair is multiplied in Q-format, and the product is
// accumulated into the result register of the row that owns it.
// Row ownership is derived from the latched row-pointer array.
module spmv_csr_accum #(
   parameter int N_ROWS = 16,
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8,
   parameter int PTR_W  = 8,
   parameter int ACC_W  = 16
) (
   input  logic                          i_clk,
   input  logic                          i_rstn,
   input  logic                          i_start,
   input  logic [(N_ROWS+1)*PTR_W-1:0]   i_row_ptr,
   input  logic                          i_nnz_valid,
   output logic                          o_nnz_ready,
   input  logic [DATA_W-1:0]             i_read_data_A,
   input  logic [DATA_W-1:0]             i_read_data_B,
   output logic [N_ROWS*ACC_W-1:0]       o_register,
   output logic [$clog2(N_ROWS)-1:0]     o_row_idx,
   output logic                          o_busy,
   output logic                          o_done,
   output logic                          o_err
);

   localparam int RIDX_W = $clog2(N_ROWS);
   localparam int PROD_W = 2 * DATA_W;
   // The sum is wide enough for a full-range product plus a full-range
   // accumulator, so saturation always sees the true value.
   localparam int SUM_W  = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;

   localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                              state_q, state_d;
   logic [(N_ROWS+1)*PTR_W-1:0]         ptr_q, ptr_d;
   logic [PTR_W-1:0]                    k_q, k_d;
   logic [RIDX_W-1:0]                   r_q, r_d;
   logic                                first_q, first_d;
   logic                                err_q, err_d;
   logic                                drain_q, drain_d;

   logic                                s1_vld_q, s1_vld_d;
   logic [DATA_W-1:0]                   s1_a_q, s1_a_d;
   logic [DATA_W-1:0]                   s1_b_q, s1_b_d;
   logic [RIDX_W-1:0]                   s1_row_q, s1_row_d;

   logic                                s2_vld_q, s2_vld_d;
   logic signed [PROD_W-1:0]            s2_prod_q, s2_prod_d;
   logic [RIDX_W-1:0]                   s2_row_q, s2_row_d;

   logic [N_ROWS-1:0][ACC_W-1:0]        acc_q, acc_d;

   logic [PTR_W-1:0]                    ptr_end;
   logic [PTR_W-1:0]                    ptr_next_row;
   logic [RIDX_W:0]                     next_row_idx;
   logic                                malformed;
   logic                                ready;
   logic                                xfer;
   logic signed [PROD_W-1:0]            prod_full;
   logic signed [SUM_W-1:0]             sum;

   // Row-pointer lookups and the monotonicity check on the latched array
   always_comb begin
      ptr_end      = ptr_q[N_ROWS*PTR_W +: PTR_W];
      next_row_idx = {1'b0, r_q} + 1'b1;
      ptr_next_row = ptr_q[next_row_idx*PTR_W +: PTR_W];
      malformed    = 1'b0;
      for (int j = 0; j < N_ROWS; j++) begin
         if (ptr_q[(j+1)*PTR_W +: PTR_W] < ptr_q[j*PTR_W +: PTR_W]) begin
            malformed = 1'b1;
         end
      end
   end

   // Control FSM: start latch, empty-row skipping, handshake, drain and done
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      k_d     = k_q;
      r_d     = r_q;
      first_d = first_q;
      err_d   = err_q;
      drain_d = drain_q;
      ready   = 1'b0;
      xfer    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               ptr_d   = i_row_ptr;
               k_d     = i_row_ptr[0 +: PTR_W];
               r_d     = '0;
               err_d   = 1'b0;
               first_d = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            first_d = 1'b0;
            if (first_q && malformed) begin
               err_d   = 1'b1;
               drain_d = 1'b0;
               state_d = S_DRAIN;
            end else if (k_q == ptr_end) begin
               drain_d = 1'b0;
               state_d = S_DRAIN;
            end else if (k_q == ptr_next_row) begin
               r_d = r_q + 1'b1;
            end else begin
               ready = 1'b1;
               if (i_nnz_valid) begin
                  xfer = 1'b1;
                  k_d  = k_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (drain_q) begin
               state_d = S_DONE;
            end else begin
               drain_d = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Datapath: operand capture, Q-format product, saturating row accumulate
   always_comb begin
      s1_vld_d  = xfer;
      s1_a_d    = xfer ? i_read_data_A : s1_a_q;
      s1_b_d    = xfer ? i_read_data_B : s1_b_q;
      s1_row_d  = xfer ? r_q : s1_row_q;

      prod_full = $signed(s1_a_q) * $signed(s1_b_q);
      s2_vld_d  = s1_vld_q;
      s2_prod_d = prod_full >>> FRAC_W;
      s2_row_d  = s1_row_q;

      acc_d = acc_q;
      sum   = {{(SUM_W-ACC_W){acc_q[s2_row_q][ACC_W-1]}}, acc_q[s2_row_q]}
            + {{(SUM_W-PROD_W){s2_prod_q[PROD_W-1]}}, s2_prod_q};
      if (s2_vld_q) begin
         if (sum > SAT_MAX) begin
            acc_d[s2_row_q] = SAT_MAX[ACC_W-1:0];
         end else if (sum < SAT_MIN) begin
            acc_d[s2_row_q] = SAT_MIN[ACC_W-1:0];
         end else begin
            acc_d[s2_row_q] = sum[ACC_W-1:0];
         end
      end
      if (state_q == S_IDLE && i_start) begin
         acc_d = '0;
      end
   end

   // State and pipeline registers; reset discards any in-flight pairs
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         k_q       <= '0;
         r_q       <= '0;
         first_q   <= 1'b0;
         err_q     <= 1'b0;
         drain_q   <= 1'b0;
         s1_vld_q  <= 1'b0;
         s1_a_q    <= '0;
         s1_b_q    <= '0;
         s1_row_q  <= '0;
         s2_vld_q  <= 1'b0;
         s2_prod_q <= '0;
         s2_row_q  <= '0;
         acc_q     <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         k_q       <= k_d;
         r_q       <= r_d;
         first_q   <= first_d;
         err_q     <= err_d;
         drain_q   <= drain_d;
         s1_vld_q  <= s1_vld_d;
         s1_a_q    <= s1_a_d;
         s1_b_q    <= s1_b_d;
         s1_row_q  <= s1_row_d;
         s2_vld_q  <= s2_vld_d;
         s2_prod_q <= s2_prod_d;
         s2_row_q  <= s2_row_d;
         acc_q     <= acc_d;
      end
   end

   assign o_nnz_ready = ready;
   assign o_register  = acc_q;
   assign o_row_idx   = (state_q == S_RUN) ? r_q : '0;
   assign o_busy      = (state_q != S_IDLE);
   assign o_done      = (state_q == S_DONE);
   assign o_err       = err_q;

endmodule
